// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: pops bytes from the command FIFO and serialises them LSB first.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_cfg #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cmd_fifo_rd_data,
  input  logic              cmd_fifo_valid,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break_req,
`endif
  output logic              cmd_fifo_rd_en,
  output logic              tx_data,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int FRAME_BITS = 1 + DATA_W + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [3:0] BRK_LAST = 4'(FRAME_BITS - 1);
`endif

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_cfg: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_STOP  = 3'd5
`ifdef UART_TX_BREAK_EN
    , S_BRK = 3'd6
`endif
  } state_t;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    if (PARITY == 1) parity_bit = ~^d;
    else             parity_bit = ^d;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  baud_r, baud_s, baud_step_s;
  logic [3:0]        bit_r, bit_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              par_r, par_s;
  logic              tx_r, tx_s, busy_r, busy_s, done_r, done_s;
  logic              bit_end_s, rd_en_s;
  logic              rst_meta_r, rst_sync_r;

  // Reset synchroniser: asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Pop strobe is only offered from IDLE with data present and reset released
`ifdef UART_TX_BREAK_EN
  assign rd_en_s = (state_r == S_IDLE) && cmd_fifo_valid && rst_sync_r && !tx_break_req;
`else
  assign rd_en_s = (state_r == S_IDLE) && cmd_fifo_valid && rst_sync_r;
`endif

  // Next-state, datapath and next-output decode
  always_comb begin
    state_s     = state_r;
    baud_s      = baud_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    par_s       = par_r;
    bit_end_s   = (baud_r == BAUD_LAST);
    baud_step_s = bit_end_s ? {CNT_W{1'b0}} : baud_r + CNT_W'(1);
    case (state_r)
      S_IDLE: begin
        baud_s = {CNT_W{1'b0}};
        bit_s  = 4'd0;
`ifdef UART_TX_BREAK_EN
        if (tx_break_req) state_s = S_BRK;
        else if (rd_en_s) state_s = S_FETCH;
        else              state_s = S_IDLE;
`else
        if (rd_en_s) state_s = S_FETCH;
        else         state_s = S_IDLE;
`endif
      end
      S_FETCH: begin
        shift_s = cmd_fifo_rd_data;
        par_s   = parity_bit(cmd_fifo_rd_data);
        state_s = S_START;
      end
      S_START: begin
        baud_s = baud_step_s;
        if (bit_end_s) state_s = S_DATA;
        else           state_s = S_START;
      end
      S_DATA: begin
        baud_s = baud_step_s;
        if (bit_end_s) begin
          shift_s = shift_r >> 1;
          if (bit_r == DATA_LAST) begin
            bit_s   = 4'd0;
            state_s = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          shift_s = shift_r;
        end
      end
      S_PAR: begin
        baud_s = baud_step_s;
        if (bit_end_s) state_s = S_STOP;
        else           state_s = S_PAR;
      end
      S_STOP: begin
        baud_s = baud_step_s;
        if (bit_end_s && bit_r == STOP_LAST) begin
          bit_s   = 4'd0;
          state_s = S_IDLE;
        end else if (bit_end_s) begin
          bit_s = bit_r + 4'd1;
        end else begin
          bit_s = bit_r;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        baud_s = baud_step_s;
        if (bit_end_s && bit_r == BRK_LAST) begin
          bit_s   = 4'd0;
          state_s = S_IDLE;
        end else if (bit_end_s) begin
          bit_s = bit_r + 4'd1;
        end else begin
          bit_s = bit_r;
        end
      end
`endif
      default: begin
        state_s = S_IDLE;
        baud_s  = {CNT_W{1'b0}};
        bit_s   = 4'd0;
      end
    endcase

    // Outputs are decoded from next state so the flops present them in step with the FSM
    case (state_s)
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = shift_s[0];
      S_PAR:   tx_s = par_s;
`ifdef UART_TX_BREAK_EN
      S_BRK:   tx_s = 1'b0;
`endif
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != S_IDLE);
    done_s = (state_s == S_STOP) && (baud_s == BAUD_LAST) && (bit_s == STOP_LAST);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r <= S_IDLE;
      baud_r  <= {CNT_W{1'b0}};
      bit_r   <= 4'd0;
      shift_r <= {DATA_W{1'b0}};
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign cmd_fifo_rd_en = rd_en_s;
  assign tx_data        = tx_r;
  assign tx_busy        = busy_r;
  assign tx_done        = done_r;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, next generation of the fixed 8N1 transmitter stage.
- Pops command bytes from the command FIFO using the existing rd_en/valid handshake and serialises them onto tx_data.
- Configurable at elaboration time: data width, baud divisor, parity mode and stop-bit count.
- Adds busy/done status outputs for the cmd_respond path and upstream arbitration.

Parameters:
- DATA_W, 8: payload bits per frame; legal range 5..9.
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200); legal >= 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- Illegal values: elaboration-time $error.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  asynchronous, active-low reset.
- cmd_fifo_rd_data  input  DATA_W  FIFO read data, valid the cycle after cmd_fifo_rd_en.
- cmd_fifo_valid  input  1  FIFO non-empty.
- cmd_fifo_rd_en  output  1  single-cycle pop strobe.
- tx_data  output  1  serial line, idles high.
- tx_busy  output  1  high from pop through the end of the last stop bit.
- tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous deassert inside the block's own logic):
  - Outputs: tx_data=1, cmd_fifo_rd_en=0, tx_busy=0, tx_done=0.
  - State: FSM=IDLE, baud counter=0, bit counter=0.
  - Reset mid-frame aborts the frame immediately; the line goes high. There is no resume, and the popped byte is lost.
- FSM states: IDLE, FETCH, START, DATA, PAR, STOP.
- IDLE:
  - tx_data=1.
  - If cmd_fifo_valid=1, drive cmd_fifo_rd_en=1 for exactly this cycle and go to FETCH. Otherwise stay.
- FETCH:
  - Capture cmd_fifo_rd_data into the shift register.
  - Compute the parity bit: odd gives ~^data, even gives ^data.
  - Go to START. tx_busy=1 from this cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in START, DATA, PAR and STOP.
  - A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - Counter width is $clog2(CLKS_PER_BIT).
- START: tx_data=0 for one bit time, then go to DATA.
- DATA:
  - Bits are sent LSB first, one per bit time.
  - Bit counter runs 0..DATA_W-1; shift right at each bit end.
  - After bit DATA_W-1, go to PAR if PARITY!=0, otherwise STOP.
- PAR: tx_data=parity bit for one bit time, then go to STOP.
- STOP:
  - tx_data=1 for STOP_BITS bit times.
  - In the final cycle: tx_done=1, tx_busy deasserts next cycle, go to IDLE.
- Back-to-back frames:
  - With cmd_fifo_valid held high, the line stays high for exactly 2 clk cycles (IDLE + FETCH) between the end of the stop bits and the next start bit.
  - The next pop occurs in the first IDLE cycle.
- FIFO handshake rules:
  - cmd_fifo_valid is ignored outside IDLE.
  - cmd_fifo_rd_en is never asserted while cmd_fifo_valid=0.
  - At most one pop per frame.
- Frame length in clk cycles = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
- All outputs are registered; tx_data is glitch-free.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input port tx_break_req (1 bit).
  - In IDLE, if tx_break_req=1, the FSM enters state BRK; this request has priority over cmd_fifo_valid.
  - BRK holds tx_data=0 with tx_busy=1 for (1 + DATA_W + (PARITY!=0) + STOP_BITS) bit times, then returns to IDLE.
  - tx_done is not pulsed after a break, and no FIFO pop occurs.
  - tx_break_req is sampled only in IDLE.
- When undefined: the port and state are absent, and behaviour is as above.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; FIFO holds 0xA5 -> rd_en pulses 1 cycle; tx_data bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clk; tx_done pulses at cycle 40 after START entry; tx_busy spans 41 cycles (FETCH through STOP).
- Same byte 0xA5 with PARITY=2 -> parity bit 0. With PARITY=1 -> parity bit 1. Frame is 44 clk.
- STOP_BITS=2, data 0x00 -> 1 start + 8 zero bits + 2 high stop bits; line high for 8 clk before tx_done.
- FIFO holds 0x3C then 0xC3, valid held -> exactly two rd_en pulses; 2-cycle high gap between frames; second frame bit sequence 0,1,1,0,0,0,0,1,1,1.
- rst driven low during DATA bit 3 -> tx_data=1 and tx_busy=0 immediately, with no clk edge needed; after release with valid=1, a new pop occurs in the first IDLE cycle.
- UART_TX_BREAK_EN defined, tx_break_req=1 and cmd_fifo_valid=1 in IDLE (8N1, CLKS_PER_BIT=4) -> tx_data low for 40 clk; no rd_en and no tx_done; the queued byte is transmitted afterwards.
